// File: rtl/ddr3_dfi_responder.sv
// rtl/ddr3_dfi_responder.sv - DFI-side PHY/DRAM stand-in: bank tracking, masked write capture, fixed-latency read return
//
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   dfi_address_i, dfi_bank_i          row (ACT) / column (READ, WRITE) address, bank select
//   dfi_cs_n_i .. dfi_we_n_i           command encoding {ras_n, cas_n, we_n}
//   dfi_cke_i, dfi_reset_n_i           commands are ignored unless cke=1 and reset_n=1
//   dfi_odt_i, dfi_rddata_en_i         accepted and ignored
//   dfi_wrdata_i/_en_i/_mask_i         write beats, mask bit 1 = byte kept
//   dfi_rddata_o/_valid_o/_dnv_o       registered read beats
//   err_o                              sticky: [0] closed bank, [1] ACT open bank,
//                                      [2] write FIFO overflow / orphan beat, [3] read overlap
module ddr3_dfi_responder #(
    parameter int DDR_READ_LATENCY = 4,
    parameter int MEM_AW           = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [14:0] dfi_address_i,
    input  logic [2:0]  dfi_bank_i,
    input  logic        dfi_cs_n_i,
    input  logic        dfi_ras_n_i,
    input  logic        dfi_cas_n_i,
    input  logic        dfi_we_n_i,
    input  logic        dfi_cke_i,
    input  logic        dfi_reset_n_i,
    input  logic        dfi_odt_i,
    input  logic [31:0] dfi_wrdata_i,
    input  logic        dfi_wrdata_en_i,
    input  logic [3:0]  dfi_wrdata_mask_i,
    input  logic        dfi_rddata_en_i,
    output logic [31:0] dfi_rddata_o,
    output logic        dfi_rddata_valid_o,
    output logic [1:0]  dfi_rddata_dnv_o,
    output logic [3:0]  err_o
);

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_ZQ  = 3'b110,
        CMD_NOP = 3'b111
    } cmd_t;

    localparam int L = DDR_READ_LATENCY;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, dfi_odt_i, dfi_rddata_en_i, dfi_address_i[2:0]};

    assign dfi_rddata_dnv_o = 2'b00;

    // Command decode
    cmd_t cmd;
    logic cmd_valid, is_act, is_pre, is_rd, is_wr;
    assign cmd       = cmd_t'({dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i});
    assign cmd_valid = !dfi_cs_n_i && dfi_cke_i && dfi_reset_n_i;
    assign is_act    = cmd_valid && (cmd == CMD_ACT);
    assign is_pre    = cmd_valid && (cmd == CMD_PRE);
    assign is_rd     = cmd_valid && (cmd == CMD_RD);
    assign is_wr     = cmd_valid && (cmd == CMD_WR);

    // Bank state
    logic [7:0]  bank_open;
    logic [14:0] bank_row [8];
    logic        sel_open;
    assign sel_open = bank_open[dfi_bank_i];

    logic rd_ok, wr_ok, closed_err;
    assign rd_ok      = is_rd && sel_open;
    assign wr_ok      = is_wr && sel_open;
    assign closed_err = (is_rd || is_wr) && !sel_open;

    // Burst base word index; the truncating cast makes high row bits alias on small arrays
    logic [MEM_AW-1:0] cmd_base;
    assign cmd_base = MEM_AW'({bank_row[dfi_bank_i], dfi_bank_i, dfi_address_i[9:3], 2'b00});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bank_open <= '0;
            for (int i = 0; i < 8; i++) bank_row[i] <= '0;
        end else if (is_act) begin
            bank_open[dfi_bank_i] <= 1'b1;
            bank_row[dfi_bank_i]  <= dfi_address_i;
        end else if (is_pre) begin
            if (dfi_address_i[10]) bank_open <= '0;
            else                   bank_open[dfi_bank_i] <= 1'b0;
        end
    end

    // Write address FIFO and beat counter
    logic [MEM_AW-1:0] wq [4];
    logic [1:0]        wq_wr, wq_rd, wr_beat;
    logic [2:0]        wq_cnt;
    logic              beat_ok, beat_err, pop, push, push_full;
    logic [MEM_AW-1:0] wr_idx;

    assign beat_ok   = dfi_wrdata_en_i && (wq_cnt != 3'd0);
    assign beat_err  = dfi_wrdata_en_i && (wq_cnt == 3'd0);
    assign pop       = beat_ok && (wr_beat == 2'd3);
    // A pop in the same cycle frees a slot, so a WRITE alongside beat 3 is accepted
    assign push_full = wr_ok && (wq_cnt == 3'd4) && !pop;
    assign push      = wr_ok && !push_full;
    assign wr_idx    = {wq[wq_rd][MEM_AW-1:2], wr_beat};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wq_wr   <= '0;
            wq_rd   <= '0;
            wq_cnt  <= '0;
            wr_beat <= '0;
        end else begin
            if (push) wq_wr <= wq_wr + 2'd1;
            if (pop)  wq_rd <= wq_rd + 2'd1;
            if (beat_ok) wr_beat <= wr_beat + 2'd1;
            case ({push, pop})
                2'b10:   wq_cnt <= wq_cnt + 3'd1;
                2'b01:   wq_cnt <= wq_cnt - 3'd1;
                default: wq_cnt <= wq_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) wq[wq_wr] <= cmd_base;
    end

    // Word array, not reset
    logic [31:0] mem [0:(1<<MEM_AW)-1];

    always_ff @(posedge clk_i) begin
        if (beat_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (!dfi_wrdata_mask_i[b]) mem[wr_idx][8*b +: 8] <= dfi_wrdata_i[8*b +: 8];
            end
        end
    end

    // Read delay line: stage k holds a READ sampled k+1 edges ago
    logic [L-1:0]      dl_valid;
    logic [MEM_AW-1:0] dl_base [L];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dl_valid <= '0;
        end else begin
            dl_valid[0] <= rd_ok;
            for (int i = 1; i < L; i++) dl_valid[i] <= dl_valid[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        dl_base[0] <= cmd_base;
        for (int i = 1; i < L; i++) dl_base[i] <= dl_base[i-1];
    end

    // Cycles since the last accepted READ, saturating at 4
    logic [2:0] rd_gap;
    logic       overlap;
    assign overlap = rd_ok && (rd_gap < 3'd4);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                rd_gap <= 3'd4;
        else if (rd_ok)           rd_gap <= 3'd1;
        else if (rd_gap != 3'd4)  rd_gap <= rd_gap + 3'd1;
    end

    // Output sequencer: a burst leaving the delay line always wins over one in progress
    logic              seq_active, rd_exit;
    logic [1:0]        seq_beat;
    logic [MEM_AW-1:0] seq_base, rd_idx;
    assign rd_exit = dl_valid[L-1];
    assign rd_idx  = rd_exit ? dl_base[L-1] : {seq_base[MEM_AW-1:2], seq_beat};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dfi_rddata_valid_o <= 1'b0;
            dfi_rddata_o       <= '0;
            seq_active         <= 1'b0;
            seq_beat           <= '0;
            seq_base           <= '0;
        end else if (rd_exit) begin
            dfi_rddata_valid_o <= 1'b1;
            dfi_rddata_o       <= mem[rd_idx];
            seq_active         <= 1'b1;
            seq_beat           <= 2'd1;
            seq_base           <= dl_base[L-1];
        end else if (seq_active) begin
            dfi_rddata_valid_o <= 1'b1;
            dfi_rddata_o       <= mem[rd_idx];
            seq_beat           <= seq_beat + 2'd1;
            seq_active         <= (seq_beat != 2'd3);
        end else begin
            dfi_rddata_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_o <= '0;
        else       err_o <= err_o | {overlap, push_full || beat_err, is_act && sel_open, closed_err};
    end

endmodule

// File: tb/tb_ddr3_dfi_responder.sv
// tb/tb_ddr3_dfi_responder.sv - self-checking bench for ddr3_dfi_responder
module tb_ddr3_dfi_responder;
    localparam int L  = 4;
    localparam int AW = 12;
    localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
                           C_WR = 3'b100, C_RD = 3'b101, C_NOP = 3'b111;

    logic        clk = 1'b0, rst = 1'b1;
    logic [14:0] addr = '0;
    logic [2:0]  bank = '0, cmd = C_NOP;
    logic        cs_n = 1'b0, cke = 1'b1, rstn = 1'b1, wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  mask = '0;
    logic [31:0] rddata;
    logic        rdvalid;
    logic [1:0]  dnv;
    logic [3:0]  err;

    ddr3_dfi_responder #(.DDR_READ_LATENCY(L), .MEM_AW(AW)) dut (
        .clk_i(clk), .rst_i(rst), .dfi_address_i(addr), .dfi_bank_i(bank),
        .dfi_cs_n_i(cs_n), .dfi_ras_n_i(cmd[2]), .dfi_cas_n_i(cmd[1]), .dfi_we_n_i(cmd[0]),
        .dfi_cke_i(cke), .dfi_reset_n_i(rstn), .dfi_odt_i(1'b0),
        .dfi_wrdata_i(wdata), .dfi_wrdata_en_i(wen), .dfi_wrdata_mask_i(mask),
        .dfi_rddata_en_i(1'b0), .dfi_rddata_o(rddata), .dfi_rddata_valid_o(rdvalid),
        .dfi_rddata_dnv_o(dnv), .err_o(err));

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          bopen [8];
    int          brow [8];
    int unsigned fifo_q [$];
    int          wbeat, last_rd, n = 0;
    int          tl [int];            // edge number -> word index driven at that edge
    logic [31:0] mem_m [int];
    logic [3:0]  mem_k [int];         // which bytes of a word are known
    logic [3:0]  err_m;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ek;

    function automatic int widx(int row, int b, int col);
        return (row * 4096 + b * 512 + (col / 8) * 4) % (1 << AW);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) bopen[i] = 0;
        fifo_q.delete();
        tl.delete();
        wbeat = 0; last_rd = n - 100; err_m = 0;
        ev = 0; ed = 0; ek = 4'hF;
    endtask

    task automatic model_step();
        int idx, base;
        n++;
        if (tl.exists(n)) begin
            idx = tl[n];
            tl.delete(n);
            ev = 1;
            ed = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            ek = mem_k.exists(idx) ? mem_k[idx] : 4'h0;
        end else ev = 0;
        if (wen) begin
            if (fifo_q.size() == 0) err_m[2] = 1;
            else begin
                idx = fifo_q[0] + wbeat;
                if (!mem_m.exists(idx)) begin mem_m[idx] = 0; mem_k[idx] = 0; end
                for (int b = 0; b < 4; b++)
                    if (!mask[b]) begin
                        mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
                        mem_k[idx][b] = 1'b1;
                    end
                wbeat++;
                if (wbeat == 4) begin wbeat = 0; void'(fifo_q.pop_front()); end
            end
        end
        if (!cs_n && cke && rstn) begin
            case (cmd)
                C_ACT: begin
                    if (bopen[bank]) err_m[1] = 1;
                    bopen[bank] = 1; brow[bank] = int'(addr);
                end
                C_PRE: begin
                    if (addr[10]) for (int i = 0; i < 8; i++) bopen[i] = 0;
                    else bopen[bank] = 0;
                end
                C_RD, C_WR: begin
                    if (!bopen[bank]) err_m[0] = 1;
                    else begin
                        base = widx(brow[bank], int'(bank), int'(addr[9:0]));
                        if (cmd == C_RD) begin
                            if (n - last_rd < 4) err_m[3] = 1;
                            last_rd = n;
                            for (int k = 0; k < 4; k++) tl[n + L + k] = base + k;
                        end else if (fifo_q.size() == 4) err_m[2] = 1;
                        else fifo_q.push_back(base);
                    end
                end
                default: ;
            endcase
        end
    endtask

    bit mon_on = 0;
    int mon_cnt, mon_first, mon_last, mon_i;

    task automatic mon_start();
        mon_on = 1; mon_cnt = 0; mon_first = -1; mon_last = -1; mon_i = 0;
    endtask

    task automatic step(input logic [2:0] c, input logic [2:0] b, input logic [14:0] a,
                        input logic we, input logic [31:0] wd, input logic [3:0] m);
        logic [31:0] km;
        @(negedge clk);
        cmd = c; bank = b; addr = a; wen = we; wdata = wd; mask = m;
        @(posedge clk);
        model_step();
        #1;
        chk("valid", 32'(rdvalid), 32'(ev));
        if (ek != 0) begin
            km = {{8{ek[3]}}, {8{ek[2]}}, {8{ek[1]}}, {8{ek[0]}}};
            chk("rddata", rddata & km, ed & km);
        end
        chk("err", 32'(err), 32'(err_m));
        chk("dnv", 32'(dnv), 32'd0);
        if (mon_on) begin
            if (rdvalid) begin
                mon_cnt++;
                if (mon_first < 0) mon_first = mon_i;
                mon_last = mon_i;
            end
            mon_i++;
        end
    endtask

    task automatic nop(input int k);
        for (int i = 0; i < k; i++) step(C_NOP, 3'd0, 15'd0, 1'b0, 32'd0, 4'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; cmd = C_NOP; wen = 0; cs_n = 0; cke = 1; rstn = 1;
        model_reset();
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    typedef struct {
        logic [2:0] c; logic [2:0] b; logic [14:0] a; logic we; logic [31:0] wd; logic [3:0] m;
        bit ck; logic ev; logic [31:0] ed; logic [3:0] ee;
    } vec_t;

    function automatic vec_t mk(logic [2:0] c, logic [2:0] b, logic [14:0] a, logic we,
                                logic [31:0] wd, logic [3:0] m, bit ck, logic e_v,
                                logic [31:0] e_d, logic [3:0] e_e);
        vec_t v;
        v.c = c; v.b = b; v.a = a; v.we = we; v.wd = wd; v.m = m;
        v.ck = ck; v.ev = e_v; v.ed = e_d; v.ee = e_e;
        return v;
    endfunction

    vec_t tbl [26];

    initial begin
        // write/read/mask vectors: READ at row 6 returns on rows 10..13, READ at 20 on 24..
        tbl[0]  = mk(C_ACT, 1, 15'd5, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(C_WR,  1, 15'h008, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            tbl[2+i] = mk(C_NOP, 0, 0, 1, 32'h11111111 * (i + 1), 0, 0, 0, 0, 0);
        tbl[6]  = mk(C_RD,  1, 15'h008, 0, 0, 0, 1, 0, 32'h0, 0);
        for (int i = 7; i < 10; i++) tbl[i] = mk(C_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            tbl[10+i] = mk(C_NOP, 0, 0, 0, 0, 0, 1, 1, 32'h11111111 * (i + 1), 0);
        tbl[14] = mk(C_NOP, 0, 0, 0, 0, 0, 1, 0, 32'h44444444, 0);
        tbl[15] = mk(C_WR,  1, 15'h008, 0, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(C_NOP, 0, 0, 1, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0);
        for (int i = 17; i < 20; i++) tbl[i] = mk(C_NOP, 0, 0, 1, 32'h0, 4'hF, 0, 0, 0, 0);
        tbl[20] = mk(C_RD,  1, 15'h008, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 21; i < 24; i++) tbl[i] = mk(C_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[24] = mk(C_NOP, 0, 0, 0, 0, 0, 1, 1, 32'hAA11CC11, 0);
        tbl[25] = mk(C_NOP, 0, 0, 0, 0, 0, 1, 1, 32'h22222222, 0);

        model_reset();
        do_reset();
        #1;
        chk("reset_valid", 32'(rdvalid), 32'd0);
        chk("reset_data", rddata, 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        // banks: open, read ok, close, read -> closed-bank error
        step(C_ACT, 2, 15'h0123, 0, 0, 0);
        nop(1);
        step(C_RD, 2, 15'h000, 0, 0, 0);
        chk("bank2_open_err", 32'(err), 32'd0);
        nop(4);
        step(C_PRE, 2, 15'h000, 0, 0, 0);
        step(C_RD, 2, 15'h000, 0, 0, 0);
        chk("bank2_closed_err", 32'(err), 32'd1);
        nop(6);

        do_reset();
        for (int i = 0; i < 26; i++) begin
            step(tbl[i].c, tbl[i].b, tbl[i].a, tbl[i].we, tbl[i].wd, tbl[i].m);
            if (tbl[i].ck) begin
                chk($sformatf("tbl%0d_valid", i), 32'(rdvalid), 32'(tbl[i].ev));
                chk($sformatf("tbl%0d_data", i), rddata, tbl[i].ed);
                chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].ee));
            end
        end
        nop(4);

        // second burst at col 0x10 so preemption is visible in the data
        step(C_WR, 1, 15'h010, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(C_NOP, 0, 0, 1, 32'hA0 + i, 0);

        // reads 4 apart: 8 contiguous beats
        mon_start();
        step(C_RD, 1, 15'h008, 0, 0, 0);
        nop(3);
        step(C_RD, 1, 15'h010, 0, 0, 0);
        nop(12);
        mon_on = 0;
        chk("b2b4_count", mon_cnt, 8);
        chk("b2b4_span", mon_last - mon_first + 1, 8);
        chk("b2b4_err3", 32'(err[3]), 32'd0);

        // reads 2 apart: overlap error, second burst starts 2 after first
        mon_start();
        step(C_RD, 1, 15'h008, 0, 0, 0);
        nop(1);
        step(C_RD, 1, 15'h010, 0, 0, 0);
        chk("b2b2_err3", 32'(err[3]), 32'd1);
        nop(10);
        mon_on = 0;
        chk("b2b2_count", mon_cnt, 6);
        chk("b2b2_span", mon_last - mon_first + 1, 6);

        // FIFO overflow: 5th WRITE (col 0x08) dropped, col 0x08 keeps old data
        do_reset();
        step(C_ACT, 1, 15'd5, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(C_WR, 1, 15'(32'h20 + 8 * i), 0, 0, 0);
        chk("ovf_err_before", 32'(err), 32'd0);
        step(C_WR, 1, 15'h008, 0, 0, 0);
        chk("ovf_err", 32'(err), 32'd4);
        for (int i = 0; i < 16; i++) step(C_NOP, 0, 0, 1, 32'hC0000000 + i, 0);
        step(C_RD, 1, 15'h008, 0, 0, 0);
        nop(4);
        chk("ovf_col8_intact", rddata, 32'hAA11CC11);
        nop(4);

        // orphan write beat
        do_reset();
        step(C_ACT, 1, 15'd5, 0, 0, 0);
        step(C_NOP, 0, 0, 1, 32'hDEADBEEF, 0);
        chk("orphan_err", 32'(err), 32'd4);
        step(C_RD, 1, 15'h020, 0, 0, 0);
        nop(4);
        chk("orphan_intact", rddata, 32'hC0000000);
        nop(4);

        // reset on second read beat
        step(C_RD, 1, 15'h008, 0, 0, 0);
        nop(5);
        chk("midrst_beat1_valid", 32'(rdvalid), 32'd1);
        #2 rst = 1;
        model_reset();
        #1;
        chk("midrst_valid", 32'(rdvalid), 32'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 0;
        mon_start();
        nop(8);
        mon_on = 0;
        chk("midrst_no_beats", mon_cnt, 0);

        // randomized traffic against the model
        for (int b = 0; b < 8; b++) step(C_ACT, 3'(b), 15'($urandom_range(0, 3)), 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            logic [2:0] c, b;
            logic [14:0] a;
            logic we;
            int r;
            r = $urandom_range(0, 9);
            c = (r < 3) ? C_RD : (r < 6) ? C_WR : (r == 6) ? C_ACT : (r == 7) ? C_PRE :
                (r == 8) ? (($urandom_range(0, 1) == 1) ? C_REF : C_MRS) : C_NOP;
            b = 3'($urandom_range(0, 2));
            if (c == C_ACT) a = 15'($urandom_range(0, 3));
            else a = 15'($urandom_range(0, 3) * 8 + $urandom_range(0, 7));
            if (c == C_PRE && $urandom_range(0, 7) == 0) a[10] = 1'b1;
            we = (fifo_q.size() != 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
            r = $urandom_range(0, 29);
            cs_n = (r == 0); cke = (r != 1); rstn = (r != 2);
            step(c, b, a, we, $urandom, 4'($urandom_range(0, 15)));
        end
        cs_n = 0; cke = 1; rstn = 1;
        nop(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
